// File: rtl/pb_pulse_stretch.sv
// Event-to-pulse stretcher: each evt strobe becomes a HOLD_CYC-wide pulse
// followed by a GAP_CYC low gap, with a saturating queue of pending events.
module pb_pulse_stretch #(
    parameter int HOLD_CYC = 25_000_000,
    parameter int GAP_CYC  = 12_500_000,
    parameter int PEND_MAX = 7,
    localparam int MAXC    = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC,
    localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1,
    localparam int PW      = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          evt,
    input  logic          clr,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pend_cnt,
    output logic          ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_GAP
    } state_t;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
    localparam logic [PW-1:0] P_MAX   = PW'(PEND_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;

    logic evt_ok;
    logic gap_end;
    logic pend_nz;
    logic take;
    logic direct;
    logic inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        evt_ok  = evt & ~clr;
        gap_end = (state_q == S_GAP) && (cnt_q == '0);
        pend_nz = (pend_q != '0);
        take    = gap_end & pend_nz;
        direct  = gap_end & ~pend_nz & evt_ok;

        unique case (state_q)
            S_IDLE: begin
                if (evt_ok) begin
                    state_d = S_HIGH;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (pend_nz || evt_ok) begin
                        state_d = S_HIGH;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // An event that starts a pulse straight out of the gap is never queued
        inc = evt_ok && (state_q != S_IDLE) && !direct;

        if (clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (inc && !take) begin
            if (pend_q == P_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (take && !inc) begin
            pend_d = pend_q - PW'(1);
        end

        out_d  = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pend_cnt = pend_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_pb_pulse_stretch.sv
// Scoreboard bench for pb_pulse_stretch: driver pushes model expectations,
// monitor pops and compares one cycle later.
module tb_pb_pulse_stretch;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PM = 3;

    logic       clk;
    logic       rst;
    logic       evt;
    logic       clr;
    logic       out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       ovf;

    pb_pulse_stretch #(
        .HOLD_CYC(H),
        .GAP_CYC (G),
        .PEND_MAX(PM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .evt     (evt),
        .clr     (clr),
        .out     (out),
        .busy    (busy),
        .pend_cnt(pend_cnt),
        .ovf     (ovf)
    );

    typedef struct packed {
        logic       out;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: a pulse is described by its first high cycle; the pulse,
    // gap and next start follow from H and G by arithmetic.
    int   cyc     = 0;
    bit   m_act   = 0;
    int   m_start = 0;
    int   m_pend  = 0;
    bit   m_ovf   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic e, input logic c);
        exp_t x;
        bit ev, ex, take, inc;
        ev   = e && !c;
        ex   = m_act && (cyc + 1 == m_start + H + G);
        take = ex && (m_pend > 0);
        inc  = ev && m_act && !(ex && m_pend == 0);
        if (!m_act) begin
            if (ev) begin
                m_act   = 1;
                m_start = cyc + 1;
            end
        end else if (ex) begin
            if (m_pend > 0 || ev) m_start = cyc + 1;
            else m_act = 0;
        end
        if (c) begin
            m_pend = 0;
            m_ovf  = 0;
        end else if (inc && !take) begin
            if (m_pend == PM) m_ovf = 1;
            else m_pend++;
        end else if (take && !inc) begin
            m_pend--;
        end
        x.out  = m_act && (cyc + 1 < m_start + H);
        x.busy = m_act;
        x.pend = 2'(m_pend);
        x.ovf  = m_ovf;
        return x;
    endfunction

    task automatic step(input logic e, input logic c);
        @(negedge clk);
        rst = 1'b0;
        evt = e;
        clr = c;
        q.push_back(model(e, c));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            evt = 1'b0;
            clr = 1'b0;
            m_act  = 0;
            m_pend = 0;
            m_ovf  = 0;
            q.push_back('0);
            cyc++;
            if (i == 0) begin
                #1;
                n_vec++;
                if ({out, busy, pend_cnt, ovf} != 5'b0) begin
                    n_err++;
                    $display("FAIL async_rst: got out=%b busy=%b pend=%0d ovf=%b, want all 0",
                             out, busy, pend_cnt, ovf);
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_vec++;
                if ({out, busy, pend_cnt, ovf} != x) begin
                    n_err++;
                    $display("FAIL cyc_%0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                             cyc, out, busy, pend_cnt, ovf,
                             x.out, x.busy, x.pend, x.ovf);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        evt = 1'b0;
        clr = 1'b0;
        do_reset(3);
        idle(4);

        // single event
        step(1, 0); idle(12);

        // queue and overflow
        step(1, 0); idle(1); step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        idle(26);

        // event on the last gap cycle
        step(1, 0); idle(5); step(1, 0); idle(14);

        // queued event plus event on gap exit
        step(1, 0); idle(1); step(1, 0); idle(3); step(1, 0); idle(24);

        // clear with coincident event while pulses are queued
        step(1, 0); idle(1); step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        idle(2); step(1, 1); idle(14);

        // async reset mid pulse, then a normal pulse
        step(1, 0); idle(2); do_reset(2); step(1, 0); idle(12);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1 + $urandom_range(0, 1));
            else step(logic'($urandom_range(0, 99) < 35),
                      logic'($urandom_range(0, 99) < 4));
        end
        idle(20);

        @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d queued, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
